// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with EX/MEM/WB forwarding.
// Define REGFILE_SCOREBOARD_EN to add the load busy scoreboard and the
// stall output. Without it, stall is tied low and the load/issue inputs
// are ignored.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_RD-1:0]          ren,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    input  logic                       ex_we,
    input  logic [ADDR_W-1:0]          ex_waddr,
    input  logic [DATA_W-1:0]          ex_wdata,
    input  logic                       mem_we,
    input  logic [ADDR_W-1:0]          mem_waddr,
    input  logic [DATA_W-1:0]          mem_wdata,
    input  logic                       wb_we,
    input  logic [ADDR_W-1:0]          wb_waddr,
    input  logic [DATA_W-1:0]          wb_wdata,
    input  logic                       wb_ld,
    input  logic                       iss_ld,
    input  logic [ADDR_W-1:0]          iss_waddr,
    output logic                       stall
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0]  mem_q;
    logic [NUM_RD-1:0][ADDR_W-1:0] ra;
    logic [NUM_RD-1:0]             fwd_hit;

    assign ra = raddr;

    // Storage: only the WB port writes; register 0 is never written so it stays 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_q <= '0;
        end else if (wb_we && wb_waddr != '0) begin
            mem_q[wb_waddr] <= wb_wdata;
        end
    end

    // Per-port read mux, youngest producer first; r0 always reads zero.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic ex_hit, mem_hit, wb_hit;
        assign ex_hit  = ex_we  && (ex_waddr  == ra[p]);
        assign mem_hit = mem_we && (mem_waddr == ra[p]);
        assign wb_hit  = wb_we  && (wb_waddr  == ra[p]);
        assign fwd_hit[p] = ex_hit || mem_hit || wb_hit;
        assign rdata[p*DATA_W +: DATA_W] =
            (ra[p] == '0) ? '0        :
            ex_hit        ? ex_wdata  :
            mem_hit       ? mem_wdata :
            wb_hit        ? wb_wdata  :
                            mem_q[ra[p]];
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [NUM_RD-1:0] hazard;

    // A port hazards only when it reads a pending load that no stage forwards.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_hz
        assign hazard[p] = ren[p] && (ra[p] != '0) && busy_q[ra[p]] && !fwd_hit[p];
    end

    assign stall = |hazard;

    // Busy next state: load completion clears, issue sets; set applied last so it wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_we && wb_ld && wb_waddr != '0) begin
            busy_d[wb_waddr] = 1'b0;
        end
        if (iss_ld && iss_waddr != '0 && !stall) begin
            busy_d[iss_waddr] = 1'b1;
        end
    end

    // Busy register; reset drops any in-flight loads.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end
`else
    logic unused_sb;

    assign stall     = 1'b0;
    assign unused_sb = ^{ren, iss_ld, iss_waddr, wb_ld, fwd_hit};
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios with literal expectations plus
// random traffic, all checked against a register/busy-set model.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
`ifdef REGFILE_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             resetn;
    logic [NR-1:0]    ren;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic             ex_we, mem_we, wb_we, wb_ld, iss_ld;
    logic [AW-1:0]    ex_waddr, mem_waddr, wb_waddr, iss_waddr;
    logic [DW-1:0]    ex_wdata, mem_wdata, wb_wdata;
    logic             stall;

    // literal expectations posted by the driver for the current cycle
    logic             lit_en0, lit_en1, lit_ens;
    logic [DW-1:0]    lit_d0, lit_d1;
    logic             lit_s;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk(clk), .resetn(resetn), .ren(ren), .raddr(raddr), .rdata(rdata),
        .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .wb_ld(wb_ld), .iss_ld(iss_ld), .iss_waddr(iss_waddr), .stall(stall)
    );

    always #5 clk = ~clk;

    // Model and the single compare process: check at each falling edge,
    // then advance the model to what the next rising edge will hold.
    initial begin
        logic [DW-1:0] m_mem [32];
        bit   [31:0]   m_busy;
        logic [AW-1:0] a;
        logic [DW-1:0] want;
        logic [DW-1:0] got;
        bit            hit;
        bit            want_stall;
        for (int r = 0; r < 32; r++) m_mem[r] = '0;
        m_busy = '0;
        forever begin
            @(negedge clk or negedge resetn);
            if (!resetn) begin
                for (int r = 0; r < 32; r++) m_mem[r] = '0;
                m_busy = '0;
            end
            if (clk == 1'b0) begin
                want_stall = 1'b0;
                for (int p = 0; p < NR; p++) begin
                    a    = raddr[p*AW +: AW];
                    got  = rdata[p*DW +: DW];
                    hit  = 1'b1;
                    if (a == 0)                          want = 0;
                    else if (ex_we  && ex_waddr  == a)   want = ex_wdata;
                    else if (mem_we && mem_waddr == a)   want = mem_wdata;
                    else if (wb_we  && wb_waddr  == a)   want = wb_wdata;
                    else begin want = m_mem[a]; hit = 1'b0; end
                    if (SB && resetn && ren[p] && a != 0 && m_busy[a] && !hit)
                        want_stall = 1'b1;
                    n_cmp++;
                    if (got !== want) begin
                        n_bad++;
                        $display("FAIL rdata%0d @%0t: got %h want %h (raddr %0d)", p, $time, got, want, a);
                    end
                end
                n_cmp++;
                if (stall !== want_stall) begin
                    n_bad++;
                    $display("FAIL stall @%0t: got %b want %b", $time, stall, want_stall);
                end
                if (lit_en0) begin
                    n_cmp++;
                    if (rdata[DW-1:0] !== lit_d0) begin
                        n_bad++;
                        $display("FAIL lit_rdata0 @%0t: got %h want %h", $time, rdata[DW-1:0], lit_d0);
                    end
                end
                if (lit_en1) begin
                    n_cmp++;
                    if (rdata[2*DW-1:DW] !== lit_d1) begin
                        n_bad++;
                        $display("FAIL lit_rdata1 @%0t: got %h want %h", $time, rdata[2*DW-1:DW], lit_d1);
                    end
                end
                if (lit_ens) begin
                    n_cmp++;
                    if (stall !== lit_s) begin
                        n_bad++;
                        $display("FAIL lit_stall @%0t: got %b want %b", $time, stall, lit_s);
                    end
                end
                if (resetn) begin
                    if (wb_we && wb_waddr != 0) m_mem[wb_waddr] = wb_wdata;
                    if (SB) begin
                        if (wb_we && wb_ld && wb_waddr != 0) m_busy[wb_waddr] = 1'b0;
                        if (iss_ld && iss_waddr != 0 && !want_stall) m_busy[iss_waddr] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic idle();
        ren = '0; raddr = '0;
        ex_we = 0; mem_we = 0; wb_we = 0; wb_ld = 0; iss_ld = 0;
        ex_waddr = '0; mem_waddr = '0; wb_waddr = '0; iss_waddr = '0;
        ex_wdata = '0; mem_wdata = '0; wb_wdata = '0;
        lit_en0 = 0; lit_en1 = 0; lit_ens = 0;
        lit_d0 = '0; lit_d1 = '0; lit_s = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd0(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic s);
        ren[0] = 1'b1; raddr[AW-1:0] = a;
        lit_en0 = 1; lit_d0 = d; lit_ens = 1; lit_s = s;
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        // in reset: storage reads 0, no stall
        rd0(5'd5, 32'h0, 1'b0);
        tick();
        tick();
        resetn = 1'b1;

        // write then read r5
        wb_we = 1; wb_waddr = 5; wb_wdata = 32'h1234_5678;
        tick();
        rd0(5'd5, 32'h1234_5678, 1'b0);
        tick();

        // forwarding priority on port 1
        for (int k = 0; k < 3; k++) begin
            ex_we = (k < 1); mem_we = (k < 2); wb_we = 1;
            ex_waddr = 3; mem_waddr = 3; wb_waddr = 3;
            ex_wdata = 32'hA; mem_wdata = 32'hB; wb_wdata = 32'hC;
            raddr[2*AW-1:AW] = 3; ren[1] = 1;
            lit_en1 = 1;
            lit_d1 = (k == 0) ? 32'hA : (k == 1) ? 32'hB : 32'hC;
            tick();
        end

        // load to r7, dependent read stalls, completion releases it
        iss_ld = 1; iss_waddr = 7;
        tick();
        rd0(5'd7, 32'h0, SB);
        tick();
        rd0(5'd7, 32'h55, 1'b0);
        wb_we = 1; wb_ld = 1; wb_waddr = 7; wb_wdata = 32'h55;
        tick();
        rd0(5'd7, 32'h55, 1'b0);
        tick();

        // busy r7 bypassed by a younger EX result
        iss_ld = 1; iss_waddr = 7;
        tick();
        rd0(5'd7, 32'h99, 1'b0);
        ex_we = 1; ex_waddr = 7; ex_wdata = 32'h99;
        tick();

        // clear and set of r4 on the same edge: set wins
        iss_ld = 1; iss_waddr = 4;
        tick();
        wb_we = 1; wb_ld = 1; wb_waddr = 4; wb_wdata = 32'h44;
        iss_ld = 1; iss_waddr = 4;
        tick();
        rd0(5'd4, 32'h44, SB);
        tick();

        // busy r2, then a mid-cycle reset pulse wipes busy and storage
        wb_we = 1; wb_waddr = 2; wb_wdata = 32'h22;
        iss_ld = 1; iss_waddr = 2;
        tick();
        #1 resetn = 1'b0;
        #2 resetn = 1'b1;
        rd0(5'd2, 32'h0, 1'b0);
        ren[1] = 1; raddr[2*AW-1:AW] = 7; lit_en1 = 1; lit_d1 = 32'h0;
        tick();

        // random traffic on a small address window to provoke hits and hazards
        for (int c = 0; c < 400; c++) begin
            ren       = NR'($urandom);
            raddr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            ex_we     = ($urandom_range(0, 3) == 0);
            mem_we    = ($urandom_range(0, 3) == 0);
            wb_we     = ($urandom_range(0, 1) == 0);
            wb_ld     = ($urandom_range(0, 1) == 0);
            iss_ld    = ($urandom_range(0, 2) == 0);
            ex_waddr  = 5'($urandom_range(0, 7));
            mem_waddr = 5'($urandom_range(0, 7));
            wb_waddr  = 5'($urandom_range(0, 7));
            iss_waddr = 5'($urandom_range(0, 7));
            ex_wdata  = $urandom;
            mem_wdata = $urandom;
            wb_wdata  = $urandom;
            if (c == 200) begin
                #1 resetn = 1'b0;
                #2 resetn = 1'b1;
            end
            tick();
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2, number of read ports, legal 1..4.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 ren  in  NUM_RD  per-port read-enable; used only for stall generation.
REQ-007 raddr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-008 rdata  out  NUM_RD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W].
REQ-009 ex_we, ex_waddr, ex_wdata  in  1/ADDR_W/DATA_W  EX-stage result; ex_we is high only when data is valid.
REQ-010 mem_we, mem_waddr, mem_wdata  in  1/ADDR_W/DATA_W  MEM-stage result; same rule.
REQ-011 wb_we, wb_waddr, wb_wdata  in  1/ADDR_W/DATA_W  write-back port; the only port that updates storage.
REQ-012 wb_ld  in  1  marks the current wb write as completing a load.
REQ-013 iss_ld, iss_waddr  in  1/ADDR_W  ID stage issues a load targeting iss_waddr this cycle.
REQ-014 stall  out  1  a read depends on a load result that is not yet available.

Function
REQ-015 Register 0 reads as 0 on every port; writes to 0 are discarded; address 0 is never busy.
REQ-016 Storage write: on posedge, if wb_we and wb_waddr!=0, array[wb_waddr] <= wb_wdata.
REQ-017 Reads are combinational, zero latency, independent per port.
REQ-018 Forward priority per port, youngest first: EX match, then MEM match, then WB match, then array; a match requires the corresponding we high and addresses equal.
REQ-019 Busy vector, one bit per register: bit set on posedge when iss_ld and iss_waddr!=0 and stall is low.
REQ-020 Busy bit cleared on posedge when wb_we, wb_ld and wb_waddr address it.
REQ-021 Simultaneous set and clear of the same bit: set wins, bit = 1.
REQ-022 Per-port hazard = ren[i] & raddr_i!=0 & busy[raddr_i] & no EX/MEM/WB forward hit on that port.
REQ-023 stall = OR of all per-port hazards; purely combinational, same cycle as the read.
REQ-024 While stall is high, iss_ld is ignored, so busy bits are not set.
REQ-025 rdata is driven by REQ-018 regardless of stall; the consumer discards it.
REQ-026 An iss_ld and a read of the same register in one cycle: the read sees the pre-edge busy value.

Reset
REQ-027 resetn low asynchronously clears all array entries and all busy bits to 0.
REQ-028 During reset, rdata follows forwarding inputs or 0; stall = 0.
REQ-029 Reset deasserting mid-operation discards in-flight loads; no busy bit survives reset.

Configuration
REQ-030 Macro REGFILE_SCOREBOARD_EN: when defined, busy vector, stall and REQ-019..REQ-026 are implemented.
REQ-031 When REGFILE_SCOREBOARD_EN is undefined: no busy storage, stall tied 0, iss_ld/iss_waddr/wb_ld/ren ignored; forwarding and storage unchanged.

Verification
REQ-032 Reset then write r5=0x1234_5678 via WB; next cycle raddr0=5, no forwards -> rdata0=0x1234_5678, stall=0.
REQ-033 Same cycle ex_we r3=0xA, mem_we r3=0xB, wb_we r3=0xC, raddr1=3 -> rdata1=0xA; drop ex_we -> 0xB; drop mem_we -> 0xC.
REQ-034 iss_ld r7; next cycle ren0=1, raddr0=7, no forwards -> stall=1; wb_we+wb_ld r7=0x55 -> stall=0, rdata0=0x55, busy[7] cleared after edge.
REQ-035 Busy r7 set, ex_we r7=0x99 (younger ALU write), raddr0=7 -> stall=0, rdata0=0x99.
REQ-036 Same edge wb_ld clears r4 and iss_ld sets r4 -> busy[4]=1 after edge; subsequent read of r4 stalls.
REQ-037 Busy r2 set, pulse resetn low mid-cycle -> busy cleared immediately, r2 reads 0, stall=0; rebuilt without REGFILE_SCOREBOARD_EN, REQ-034 stimulus -> stall stays 0.
